// File: rtl/cbsc_pkg.sv
// Shared constants and FSM state type for the stochastic-number generator/counter pair.
package cbsc_pkg;

   localparam int CBSC_N_BITS = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } cbsc_state_e;

endpackage

// File: rtl/cbsc_sn_counter_if.sv
// Handshake/result bundle between a stochastic bitstream source and the counter.
interface cbsc_sn_counter_if #(
   parameter int N_BITS = cbsc_pkg::CBSC_N_BITS
);
   logic              start;
   logic              x_sn;
   logic              in_valid;
   logic              busy;
   logic [N_BITS:0]   y;
   logic              y_valid;

   modport master (
      output start, x_sn, in_valid,
      input  busy, y, y_valid
   );

   modport slave (
      input  start, x_sn, in_valid,
      output busy, y, y_valid
   );
endinterface

// File: rtl/cbsc_sn_win_cnt.sv
// Window bit counter: down-counts remaining valid bits, tc marks the last bit of the window.
module cbsc_sn_win_cnt #(
   parameter int N_BITS = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic first_bit,
   input  logic step,
   output logic tc
);
   localparam logic [N_BITS-1:0] ALL_BITS = {N_BITS{1'b1}};
   localparam logic [N_BITS-1:0] ONE      = N_BITS'(1);

   logic [N_BITS-1:0] rem_q;

   // rem_q holds (valid bits still to sample) - 1; a valid start-cycle bit is already consumed
   always_ff @(posedge clk) begin
      if (!rst) begin
         rem_q <= '0;
      end else if (load) begin
         rem_q <= first_bit ? (ALL_BITS - ONE) : ALL_BITS;
      end else if (step) begin
         rem_q <= rem_q - ONE;
      end
   end

   assign tc = (rem_q == '0);
endmodule

// File: rtl/cbsc_sn_counter.sv
// Stochastic bitstream to binary decoder over windows of 2^N_BITS valid bits.
// Optional macro CBSC_SN_SAT_EN clamps the all-ones window result to 2^N_BITS-1.
//
// state | meaning
// IDLE  | waiting for start; stream ignored
// ACCUM | window open, counting valid bits and ones
// DONE  | one-cycle result strobe; start here opens the next window
module cbsc_sn_counter
   import cbsc_pkg::*;
#(
   parameter int N_BITS = CBSC_N_BITS
) (
   input logic               clk,
   input logic               rst,
   cbsc_sn_counter_if.slave  bus
);
   localparam logic [N_BITS:0] W_CNT   = {1'b1, {N_BITS{1'b0}}};
   localparam logic [N_BITS:0] SAT_MAX = {1'b0, {N_BITS{1'b1}}};

   cbsc_state_e     state_q, state_d;
   logic [N_BITS:0] ones_q, ones_d;
   logic [N_BITS:0] y_q, y_d;
   logic [N_BITS:0] ones_sum;
   logic [N_BITS:0] y_final;
   logic            cnt_load, cnt_step, cnt_tc;

   cbsc_sn_win_cnt #(.N_BITS(N_BITS)) u_win_cnt (
      .clk       (clk),
      .rst       (rst),
      .load      (cnt_load),
      .first_bit (bus.in_valid),
      .step      (cnt_step),
      .tc        (cnt_tc)
   );

   assign ones_sum = ones_q + {{N_BITS{1'b0}}, bus.x_sn};

`ifdef CBSC_SN_SAT_EN
   assign y_final = (ones_sum == W_CNT) ? SAT_MAX : ones_sum;
`else
   assign y_final = ones_sum;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         ones_q  <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         ones_q  <= ones_d;
         y_q     <= y_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ones_d   = ones_q;
      y_d      = y_q;
      cnt_load = 1'b0;
      cnt_step = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d  = ACCUM;
               cnt_load = 1'b1;
               ones_d   = {{N_BITS{1'b0}}, bus.in_valid & bus.x_sn};
            end else begin
               state_d = IDLE;
            end
         end
         ACCUM: begin
            if (bus.in_valid) begin
               cnt_step = 1'b1;
               ones_d   = ones_sum;
               if (cnt_tc) begin
                  state_d = DONE;
                  y_d     = y_final;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.busy    = (state_q == ACCUM);
   assign bus.y_valid = (state_q == DONE);
   assign bus.y       = y_q;
endmodule

// File: tb/tb_cbsc_sn_counter.sv
// Randomized self-checking bench for cbsc_sn_counter against a window-sum reference model.
module tb_cbsc_sn_counter;
   localparam int NB = 7;
   localparam int W  = 1 << NB;
`ifdef CBSC_SN_SAT_EN
   localparam int CAP = W - 1;
`else
   localparam int CAP = W;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   exp_y = 0;

   cbsc_sn_counter_if #(.N_BITS(NB)) bus ();

   cbsc_sn_counter #(.N_BITS(NB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input bit s, input bit v, input bit b);
      bus.start    = s;
      bus.in_valid = v;
      bus.x_sn     = b;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         tick(1'b0, 1'($urandom), 1'($urandom));
         check("idle_busy", 32'(bus.busy), 0);
         check("idle_yv", 32'(bus.y_valid), 0);
         check("idle_y_hold", 32'(bus.y), exp_y);
      end
   endtask

   // mode 0: counter pattern (bit i = i < xval), 1: all ones, 2: all zeros, 3: random bits
   task automatic run_window(input int mode, input int xval, input int n_gaps, input bit poke_start);
      bit bits [W];
      int sum = 0;
      int r   = W;
      int g   = n_gaps;
      int idx = 0;
      int cyc = 0;
      bit v, s;
      for (int i = 0; i < W; i++) begin
         case (mode)
            0:       bits[i] = (i < xval);
            1:       bits[i] = 1'b1;
            2:       bits[i] = 1'b0;
            default: bits[i] = 1'($urandom);
         endcase
         sum += int'(bits[i]);
      end
      while (r > 0) begin
         v = (g == 0) || ($urandom_range(0, r + g - 1) < r);
         s = (cyc == 0) ? 1'b1 : (poke_start ? 1'($urandom) : 1'b0);
         if (v) begin
            tick(s, 1'b1, bits[idx]);
            idx++;
            r--;
         end else begin
            tick(s, 1'b0, 1'($urandom));
            g--;
         end
         cyc++;
         if (r > 0) begin
            check("win_busy", 32'(bus.busy), 1);
            check("win_no_yv", 32'(bus.y_valid), 0);
            check("win_y_hold", 32'(bus.y), exp_y);
         end
      end
      exp_y = (sum > CAP) ? CAP : sum;
      check("done_yv", 32'(bus.y_valid), 1);
      check("done_y", 32'(bus.y), exp_y);
      check("done_busy", 32'(bus.busy), 0);
   endtask

   initial begin
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.x_sn     = 1'b0;
      rst          = 1'b0;
      tick(1'b1, 1'b1, 1'b1);
      tick(1'b1, 1'b1, 1'b1);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_yv", 32'(bus.y_valid), 0);
      check("rst_y", 32'(bus.y), 0);
      rst = 1'b1;
      idle(3);

      run_window(0, 96, 0, 1'b0);
      idle(2);
      run_window(1, 0, 0, 1'b0);
      idle(2);
      run_window(2, 0, 0, 1'b0);
      idle(2);
      run_window(1, 0, 50, 1'b0);
      idle(2);

      tick(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 59; i++) tick(1'b0, 1'b1, 1'b1);
      check("mid_busy_open", 32'(bus.busy), 1);
      rst = 1'b0;
      tick(1'b0, 1'b1, 1'b1);
      exp_y = 0;
      check("mid_rst_busy", 32'(bus.busy), 0);
      check("mid_rst_y", 32'(bus.y), 0);
      check("mid_rst_yv", 32'(bus.y_valid), 0);
      rst = 1'b1;
      idle(W + 5);
      run_window(0, 77, 5, 1'b0);
      idle(1);

      run_window(0, 40, 3, 1'b1);
      run_window(1, 0, 0, 1'b0);
      idle(1);

      for (int k = 0; k < 6; k++) begin
         run_window(3, 0, $urandom_range(0, 20), 1'($urandom));
         if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
      end
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
